// File: rtl/ldl_slot_arb_pkg.sv
// Shared types and helpers for the time-slice round-robin slot arbiter.
package ldl_slot_arb_pkg;

   localparam int unsigned MAX_N   = 32;
   localparam int unsigned MAX_IDW = 5;

   typedef enum logic {IDLE, GRANT} slot_st_t;

   typedef struct packed {
      logic               found;
      logic [MAX_IDW-1:0] idx;
   } rr_res_t;

   // First set bit of req strictly after ptr, cyclic over n requesters.
   function automatic rr_res_t rr_first(logic [MAX_N-1:0] req,
                                        int unsigned n,
                                        int unsigned ptr);
      rr_res_t res;
      int unsigned j;
      res = '0;
      for (int unsigned off = n; off >= 1; off--) begin
         j = (ptr + off) % n;
         if (req[j]) begin
            res.found = 1'b1;
            res.idx   = MAX_IDW'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ldl_slot_arb_if.sv
// Requester-side bus of the slot arbiter: requests, releases, slot config and grant status.
interface ldl_slot_arb_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = 8
);
   localparam int unsigned IDW = $clog2(N);

   logic           en;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [CW-1:0]  slot_len;
   logic [N-1:0]   gnt;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   logic [CW-1:0]  slot_cnt;
   logic           expire;

   modport master (
      output en, req, done, slot_len,
      input  gnt, gnt_vld, gnt_id, slot_cnt, expire
   );

   modport slave (
      input  en, req, done, slot_len,
      output gnt, gnt_vld, gnt_id, slot_cnt, expire
   );
endinterface

// File: rtl/ldl_rr_pick.sv
// Combinational cyclic priority pick: first set req bit after ptr, wrapping at N.
module ldl_rr_pick #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] idx,
   output logic           found
);

   // Scan farthest offset first so the nearest set bit after ptr wins.
   always_comb begin
      int unsigned j;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned off = N; off >= 1; off--) begin
         j = (32'(ptr) + off) % N;
         if (req[j]) begin
            idx   = IDW'(j);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldl_slot_arb.sv
// Time-slice round-robin arbiter: one owner at a time for up to slot_len+1 cycles,
// ending early on owner done or request drop.
module ldl_slot_arb
   import ldl_slot_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   ldl_slot_arb_if.slave bus
);

   localparam int unsigned IDW = $clog2(N);

   slot_st_t       state_q,   state_nxt;
   logic [N-1:0]   gnt_q,     gnt_nxt;
   logic           gnt_vld_q, gnt_vld_nxt;
   logic [IDW-1:0] gnt_id_q,  gnt_id_nxt;
   logic [CW-1:0]  cnt_q,     cnt_nxt;
   logic [CW-1:0]  lim_q,     lim_nxt;
   logic [IDW-1:0] ptr_q,     ptr_nxt;
   logic           expire_q,  expire_nxt;

   logic [N-1:0]   pick_req;
   logic [IDW-1:0] pick_ptr;
   logic [IDW-1:0] pick_idx;
   logic           pick_found;

   logic own_req;
   logic own_done;
   logic end_to;
   logic end_any;

   assign own_req  = bus.req[gnt_id_q];
   assign own_done = bus.done[gnt_id_q];
   assign end_to   = (cnt_q == lim_q);
   assign end_any  = end_to || own_done || !own_req;

   // While granted, the owner is masked out and the scan starts just after it.
   assign pick_req = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;
   assign pick_ptr = (state_q == GRANT) ? gnt_id_q : ptr_q;

   ldl_rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_nxt  = state_q;
      gnt_nxt    = gnt_q;
      gnt_id_nxt = gnt_id_q;
      cnt_nxt    = cnt_q;
      lim_nxt    = lim_q;
      ptr_nxt    = ptr_q;
      expire_nxt = 1'b0;
      if (bus.en) begin
         unique case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_nxt  = GRANT;
                  gnt_nxt    = N'(1) << pick_idx;
                  gnt_id_nxt = pick_idx;
                  cnt_nxt    = '0;
                  lim_nxt    = bus.slot_len;
               end
            end
            GRANT: begin
               if (!end_any) begin
                  cnt_nxt = cnt_q + CW'(1);
               end else begin
                  ptr_nxt    = gnt_id_q;
                  cnt_nxt    = '0;
                  expire_nxt = end_to && !own_done && own_req;
                  if (pick_found) begin
                     gnt_nxt    = N'(1) << pick_idx;
                     gnt_id_nxt = pick_idx;
                     lim_nxt    = bus.slot_len;
                  end else if (own_req) begin
                     lim_nxt = bus.slot_len;
                  end else begin
                     state_nxt = IDLE;
                     gnt_nxt   = '0;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      gnt_vld_nxt = |gnt_nxt;
   end

   // Register update; en=0 holds everything except the expire pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         gnt_id_q  <= '0;
         cnt_q     <= '0;
         lim_q     <= '0;
         ptr_q     <= IDW'(N - 1);
         expire_q  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         gnt_q     <= gnt_nxt;
         gnt_vld_q <= gnt_vld_nxt;
         gnt_id_q  <= gnt_id_nxt;
         cnt_q     <= cnt_nxt;
         lim_q     <= lim_nxt;
         ptr_q     <= ptr_nxt;
         expire_q  <= expire_nxt;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.gnt_vld  = gnt_vld_q;
   assign bus.gnt_id   = gnt_id_q;
   assign bus.slot_cnt = cnt_q;
   assign bus.expire   = expire_q;

endmodule

// File: tb/tb_ldl_slot_arb.sv
// Bench for ldl_slot_arb (N=4, CW=4): slot-level reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_ldl_slot_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   ldl_slot_arb_if #(.N(N), .CW(CW)) bus ();

   ldl_slot_arb #(.N(N), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = idle), cycles used, latched limit, rotation pointer.
   int m_own, m_last, m_used, m_lim, m_ptr;
   bit m_exp;

   function automatic int next_after(input logic [N-1:0] r, input int from);
      for (int o = 1; o <= int'(N); o++)
         if (r[(from + o) % N]) return (from + o) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int w, k;
      logic [N-1:0] r;
      bit over, fin, gone;
      if (!rst) begin
         m_own = -1; m_last = 0; m_used = 0; m_lim = 0; m_ptr = N - 1; m_exp = 0;
      end else if (!bus.en) begin
         m_exp = 0;
      end else if (m_own < 0) begin
         m_exp = 0;
         w = next_after(bus.req, m_ptr);
         if (w >= 0) begin
            m_own = w; m_last = w; m_used = 0; m_lim = int'(bus.slot_len);
         end
      end else begin
         k    = m_own;
         over = (m_used == m_lim);
         fin  = bus.done[k];
         gone = !bus.req[k];
         if (!(over || fin || gone)) begin
            m_used++;
            m_exp = 0;
         end else begin
            m_exp  = over && !fin && !gone;
            m_ptr  = k;
            r      = bus.req;
            r[k]   = 1'b0;
            w      = next_after(r, k);
            if (w < 0 && !gone) w = k;
            m_used = 0;
            if (w >= 0) begin
               m_own = w; m_last = w; m_lim = int'(bus.slot_len);
            end else begin
               m_own = -1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      logic [N-1:0] ge;
      ge = (m_own < 0) ? '0 : N'(1 << m_own);
      chk("model_gnt",      32'(bus.gnt),      32'(ge));
      chk("model_gnt_vld",  32'(bus.gnt_vld),  32'(m_own >= 0));
      chk("model_gnt_id",   32'(bus.gnt_id),   32'(m_last));
      chk("model_slot_cnt", 32'(bus.slot_cnt), 32'(m_used));
      chk("model_expire",   32'(bus.expire),   32'(m_exp));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst          = 1'b0;
      bus.en       = 1'b1;
      bus.req      = 4'hF;
      bus.done     = 4'h0;
      bus.slot_len = 4'd2;

      // Reset holds the grant off even with all requests up.
      tick(); tick();
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_cnt", 32'(bus.slot_cnt), 32'h0);
      rst = 1'b1;
      tick();
      chk("first_gnt", 32'(bus.gnt), 32'h1);

      // Timeout rotation: 3 cycles each, expire on first cycle of each follow-on grant.
      for (int o = 0; o < 4; o++) begin
         for (int c = 0; c < 3; c++) begin
            chk("rr_gnt",    32'(bus.gnt),      32'(1 << o));
            chk("rr_cnt",    32'(bus.slot_cnt), 32'(c));
            chk("rr_expire", 32'(bus.expire),   32'(c == 0 && o != 0));
            tick();
         end
      end
      chk("rr_wrap_gnt", 32'(bus.gnt), 32'h1);
      chk("rr_wrap_exp", 32'(bus.expire), 32'h1);

      // Owner 0 drops its request; owner 1 takes over with no timeout reported.
      bus.slot_len = 4'd5;
      bus.req      = 4'b0110;
      tick();
      chk("drop_gnt", 32'(bus.gnt), 32'b0010);
      chk("drop_exp", 32'(bus.expire), 32'h0);
      bus.done = 4'b1000;
      tick();
      chk("foreign_done_gnt", 32'(bus.gnt), 32'b0010);
      chk("foreign_done_cnt", 32'(bus.slot_cnt), 32'h1);
      bus.done = 4'b0010;
      tick();
      chk("done_gnt", 32'(bus.gnt), 32'b0100);
      chk("done_cnt", 32'(bus.slot_cnt), 32'h0);
      chk("done_exp", 32'(bus.expire), 32'h0);
      bus.done = 4'h0;

      // Go idle, then a sole requester with a 1-cycle slot.
      bus.req = 4'h0;
      tick();
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      chk("idle_vld", 32'(bus.gnt_vld), 32'h0);
      chk("idle_id",  32'(bus.gnt_id), 32'h2);
      bus.req      = 4'b0100;
      bus.slot_len = 4'd0;
      tick();
      chk("sole_first_gnt", 32'(bus.gnt), 32'b0100);
      chk("sole_first_exp", 32'(bus.expire), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sole_gnt", 32'(bus.gnt), 32'b0100);
         chk("sole_cnt", 32'(bus.slot_cnt), 32'h0);
         chk("sole_exp", 32'(bus.expire), 32'h1);
      end
      bus.req = 4'h0;
      tick();
      chk("sole_release_gnt", 32'(bus.gnt), 32'h0);
      chk("sole_release_exp", 32'(bus.expire), 32'h0);

      // Enable freeze and mid-slot slot_len change.
      bus.req      = 4'b0011;
      bus.slot_len = 4'd3;
      tick();
      chk("en_gnt0", 32'(bus.gnt), 32'b0001);
      tick();
      chk("en_cnt1", 32'(bus.slot_cnt), 32'h1);
      bus.en       = 1'b0;
      bus.slot_len = 4'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("frz_gnt", 32'(bus.gnt), 32'b0001);
         chk("frz_cnt", 32'(bus.slot_cnt), 32'h1);
      end
      bus.en = 1'b1;
      tick(); tick();
      chk("old_lim_cnt", 32'(bus.slot_cnt), 32'h3);
      tick();
      chk("new_slot_gnt", 32'(bus.gnt), 32'b0010);
      chk("new_slot_exp", 32'(bus.expire), 32'h1);
      for (int i = 0; i < 7; i++) tick();
      chk("new_lim_cnt", 32'(bus.slot_cnt), 32'h7);
      chk("new_lim_gnt", 32'(bus.gnt), 32'b0010);
      tick();
      chk("back0_gnt", 32'(bus.gnt), 32'b0001);
      chk("back0_exp", 32'(bus.expire), 32'h1);
      bus.en = 1'b0;
      tick();
      chk("frz_exp_clear", 32'(bus.expire), 32'h0);
      chk("frz_exp_gnt",   32'(bus.gnt), 32'b0001);
      bus.en = 1'b1;
      tick();
      chk("pre_rst_cnt", 32'(bus.slot_cnt), 32'h1);

      // Asynchronous reset between edges; pointer restore shows in the next winner.
      bus.req = 4'b0110;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(bus.gnt), 32'h0);
      chk("arst_vld", 32'(bus.gnt_vld), 32'h0);
      chk("arst_cnt", 32'(bus.slot_cnt), 32'h0);
      chk("arst_id",  32'(bus.gnt_id), 32'h0);
      tick();
      rst = 1'b1;
      tick();
      chk("arst_regrant", 32'(bus.gnt), 32'b0010);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
